// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the 2x polyphase interpolating FIR.
//
// Contents:
//   NTAPS, NPHASE, NHIST   filter geometry (16 taps, 2 phases, 8-deep history)
//   DATA_W, PROD_W, ACC_W  sample, product and accumulator widths
//   SHIFT                  output scaling shift (acc >>> SHIFT)
//   TAPS                   coefficient table h[0..15]
//   state_t                FSM state encoding (IDLE, MAC, OUT)
//   scale_sat()            accumulator -> Q1.15 output conversion
//
// Configuration macro: FIR_INTERP2_ROUND_EN
//   defined   : round half up (add 2^(SHIFT-1) before the shift)
//   undefined : truncate toward minus infinity
//   Saturation to the 16-bit signed range applies in both builds.

package fir_pkg;

    localparam int unsigned NTAPS  = 16;
    localparam int unsigned NPHASE = 2;
    localparam int unsigned NHIST  = NTAPS / NPHASE;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 36;
    localparam int unsigned SHIFT  = 14;

    localparam logic signed [DATA_W-1:0] TAPS [NTAPS] = '{
        16'sd512,  16'sd1024, 16'sd2048, 16'sd4096,
        16'sd8192, 16'sd4096, 16'sd2048, 16'sd1024,
        16'sd512,  16'sd256,  16'sd128,  16'sd64,
        16'sd32,   16'sd16,   16'sd8,    16'sd4
    };

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

`ifdef FIR_INTERP2_ROUND_EN
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(2 ** (SHIFT - 1));
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Scale the accumulator back to Q1.15 and clamp to the 16-bit range.
    function automatic logic signed [DATA_W-1:0] scale_sat(
        input logic signed [ACC_W-1:0] acc
    );
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
`ifdef FIR_INTERP2_ROUND_EN
        biased = acc + ROUND_BIAS;
`else
        biased = acc;
`endif
        shifted = biased >>> SHIFT;
        if (shifted > SAT_MAX) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            return {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return shifted[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac -- single multiply-accumulate lane for fir_interp2.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, clears the accumulator
//   clr     clear the accumulator (start of a new output sample)
//   en      add coef*sample to the accumulator this cycle
//   coef    signed coefficient (Q1.15 scale)
//   sample  signed input sample (Q1.15)
//   acc     signed ACC_W-bit accumulator, registered
//
// The product is kept at full 32-bit precision and sign-extended into
// the accumulator.

module fir_mac
    import fir_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [PROD_W-1:0] prod;

    always_comb begin
        prod = coef * sample;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_interp2.sv
// fir_interp2 -- 2x polyphase interpolating FIR, one MAC per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    Q1.15 input sample
//   in_valid   in_data is valid
//   in_ready   block can accept a sample (high only when idle)
//   out_data   Q1.15 interpolated sample, registered
//   out_valid  out_data is valid, registered
//   out_ready  downstream accepts out_data
//
// Each accepted input produces two outputs: phase 0 uses the even taps,
// phase 1 the odd taps, both over the 8-entry input history.
//
// Configuration macro: FIR_INTERP2_ROUND_EN (see fir_pkg) selects
// round-half-up instead of truncation when scaling the accumulator.

module fir_interp2
    import fir_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    // One extra bit so k can reach NHIST, marking "all products summed".
    localparam int unsigned K_W   = $clog2(NHIST) + 1;
    localparam int unsigned IDX_W = $clog2(NTAPS);

    state_t                    state_q;
    state_t                    state_d;
    logic signed [DATA_W-1:0]  x_hist [NHIST];
    logic [K_W-1:0]            k_q;
    logic                      phase_q;
    logic                      in_hs;
    logic                      out_hs;
    logic                      k_done;
    logic                      mac_clr;
    logic                      mac_en;
    logic [IDX_W-1:0]          tap_idx;
    logic signed [DATA_W-1:0]  coef;
    logic signed [DATA_W-1:0]  sample;
    logic signed [ACC_W-1:0]   acc;

    always_comb begin
        in_ready = (state_q == IDLE);
    end

    always_comb begin
        in_hs  = in_valid && (state_q == IDLE);
        out_hs = out_valid && out_ready;
        k_done = (k_q == K_W'(NHIST));
    end

    // Tap h[2k + phase] pairs with history entry x[n-k].
    always_comb begin
        tap_idx = {k_q[K_W-2:0], phase_q};
        coef    = TAPS[tap_idx];
        sample  = x_hist[k_q[K_W-2:0]];
    end

    fir_mac u_mac (
        .clk    (clk),
        .rst    (rst),
        .clr    (mac_clr),
        .en     (mac_en),
        .coef   (coef),
        .sample (sample),
        .acc    (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_hs) begin
                    state_d = MAC;
                    mac_clr = 1'b1;
                end
            end
            MAC: begin
                if (k_done) begin
                    state_d = OUT;
                end else begin
                    mac_en = 1'b1;
                end
            end
            OUT: begin
                if (out_hs) begin
                    if (!phase_q) begin
                        state_d = MAC;
                        mac_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The eighth product lands in acc on the eighth MAC edge; the following
    // MAC cycle (k == NHIST) registers the scaled result from the settled acc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NHIST; i++) begin
                x_hist[i] <= '0;
            end
            k_q       <= '0;
            phase_q   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_hs) begin
                        x_hist[0] <= $signed(in_data);
                        for (int unsigned i = 1; i < NHIST; i++) begin
                            x_hist[i] <= x_hist[i-1];
                        end
                        k_q     <= '0;
                        phase_q <= 1'b0;
                    end
                end
                MAC: begin
                    if (k_done) begin
                        out_data  <= scale_sat(acc);
                        out_valid <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        k_q       <= '0;
                        phase_q   <= ~phase_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_interp2.sv
`timescale 1ns/1ps
module tb_fir_interp2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;

    int     taps [16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                          512, 256, 128, 64, 32, 16, 8, 4};
    longint hist [8];

    fir_interp2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: history of accepted samples, newest first.
    function automatic void model_clear();
        for (int i = 0; i < 8; i++) hist[i] = 0;
    endfunction

    function automatic void model_push(input int x);
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = x;
    endfunction

    function automatic int model_y(input int ph);
        longint s;
        s = 0;
        for (int k = 0; k < 8; k++) s += longint'(taps[2*k+ph]) * hist[k];
`ifdef FIR_INTERP2_ROUND_EN
        s += 8192;
`endif
        s = s >>> 14;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return int'(s);
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        model_clear();
    endtask

    // Cycles (edges) until out_valid is seen, -1 if it never shows up.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
    endtask

    // Offer one sample from idle and collect both outputs; stall = cycles
    // out_ready is held low after each output appears.
    task automatic push(input int x, input int stall,
                        output int y0, output int y1,
                        output int lat0, output int lat1,
                        output logic drop0, output logic drop1);
        in_data = 16'(x); in_valid = 1'b1; out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        wait_valid(lat0);
        y0 = int'($signed(out_data));
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        drop0 = out_valid;
        out_ready = (stall == 0);
        wait_valid(lat1);
        y1 = int'($signed(out_data));
        repeat (stall) tick();
        out_ready = 1'b1;
        tick();
        drop1 = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'd1234; out_ready = 1'b1;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 16'd0) begin failures++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        begin
            int seen;
            seen = 0;
            repeat (12) begin tick(); if (out_valid !== 1'b0) seen++; end
            checks++;
            if (seen != 0) begin failures++; $display("FAIL rst_no_phantom: got %0d valid cycles expected 0", seen); end
        end
        model_clear();
    endtask

    task automatic test_impulse(input string name, input bit with_reset);
        int imp [16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                         512, 256, 128, 64, 32, 16, 8, 4};
        int y0, y1, l0, l1, e0, e1, x;
        logic d0, d1;
        if (with_reset) do_reset();
        for (int p = 0; p < 10; p++) begin
            x = (p == 0) ? 16384 : 0;
            model_push(x);
            push(x, 0, y0, y1, l0, l1, d0, d1);
            e0 = (p < 8) ? imp[2*p] : 0;
            e1 = (p < 8) ? imp[2*p+1] : 0;
            checks++;
            if (y0 !== e0) begin failures++; $display("FAIL %s y[%0d]: got %0d expected %0d", name, 2*p, y0, e0); end
            checks++;
            if (y1 !== e1) begin failures++; $display("FAIL %s y[%0d]: got %0d expected %0d", name, 2*p+1, y1, e1); end
            checks++;
            if (l0 != 9 || l1 != 9) begin
                failures++;
                $display("FAIL %s latency[%0d]: got %0d/%0d expected 9/9", name, p, l0, l1);
            end
            checks++;
            if (d0 !== 1'b0 || d1 !== 1'b0) begin
                failures++;
                $display("FAIL %s valid_drop[%0d]: got %b/%b expected 0/0", name, p, d0, d1);
            end
        end
    endtask

    task automatic test_dc();
        int y0, y1, l0, l1;
        logic d0, d1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            model_push(32767);
            push(32767, 0, y0, y1, l0, l1, d0, d1);
            if (i >= 7) begin
                checks++;
                if (y0 !== 26959 || y1 !== 21159) begin
                    failures++;
                    $display("FAIL dc_pos[%0d]: got %0d/%0d expected 26959/21159", i, y0, y1);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            model_push(-32768);
            push(-32768, 0, y0, y1, l0, l1, d0, d1);
            if (i >= 7) begin
                checks++;
                if (y0 !== -26960 || y1 !== -21160) begin
                    failures++;
                    $display("FAIL dc_neg[%0d]: got %0d/%0d expected -26960/-21160", i, y0, y1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        do_reset();
        in_data = 16'd16384; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_data = '0;
        model_push(16384);
        wait_valid(lat);
        checks++;
        if (lat != 9) begin failures++; $display("FAIL bp_latency0: got %0d expected 9", lat); end
        bad = 0;
        repeat (5) begin
            if (out_valid !== 1'b1 || out_data !== 16'd512 || in_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0 || out_data !== 16'd512) begin
            failures++;
            $display("FAIL bp_hold: got %0d bad cycles data=%0d expected 0 bad data=512", bad, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drop: got %b expected 0", out_valid); end
        wait_valid(lat);
        checks++;
        if (lat != 9 || int'($signed(out_data)) !== model_y(1) || out_data !== 16'd1024) begin
            failures++;
            $display("FAIL bp_next: got lat=%0d data=%0d expected lat=9 data=1024", lat, out_data);
        end
        tick();
    endtask

    task automatic test_busy();
        int e [4];
        int got [4];
        int n_acc, n_out, outs_at_200;
        logic hs_in, hs_out;
        do_reset();
        model_push(100); e[0] = model_y(0); e[1] = model_y(1);
        model_push(200); e[2] = model_y(0); e[3] = model_y(1);
        n_acc = 0; n_out = 0; outs_at_200 = -1;
        for (int i = 0; i < 4; i++) got[i] = 0;
        in_data = 16'd100; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (n_out < 4) got[n_out] = int'($signed(out_data));
                n_out++;
            end
            if (hs_in) begin
                n_acc++;
                if (in_data == 16'd200) outs_at_200 = n_out;
            end
            tick();
            if (hs_in) begin
                if (in_data == 16'd100) in_data = 16'd200;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (n_acc != 2) begin failures++; $display("FAIL busy_accepts: got %0d expected 2", n_acc); end
        checks++;
        if (outs_at_200 != 2) begin failures++; $display("FAIL busy_accept_point: got %0d expected 2", outs_at_200); end
        checks++;
        if (n_out != 4) begin failures++; $display("FAIL busy_out_count: got %0d expected 4", n_out); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== e[i]) begin failures++; $display("FAIL busy_out[%0d]: got %0d expected %0d", i, got[i], e[i]); end
        end
    endtask

    task automatic test_random();
        int x, st, y0, y1, l0, l1, e0, e1;
        logic d0, d1;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            x  = int'($urandom_range(65535)) - 32768;
            st = int'($urandom_range(3));
            model_push(x);
            e0 = model_y(0);
            e1 = model_y(1);
            push(x, st, y0, y1, l0, l1, d0, d1);
            checks++;
            if (y0 !== e0 || y1 !== e1) begin
                failures++;
                $display("FAIL rand[%0d] x=%0d: got %0d/%0d expected %0d/%0d", i, x, y0, y1, e0, e1);
            end
            checks++;
            if (l0 != 9 || l1 != 9 || d0 !== 1'b0 || d1 !== 1'b0) begin
                failures++;
                $display("FAIL rand_timing[%0d]: got lat=%0d/%0d drop=%b/%b expected 9/9 0/0", i, l0, l1, d0, d1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        in_data = 16'd16384; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = '0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        rst = 1'b0;
        model_clear();
        seen = 0;
        repeat (12) begin tick(); if (out_valid !== 1'b0) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_rst_discard: got %0d valid cycles expected 0", seen); end
        test_impulse("impulse_after_rst", 1'b0);
    endtask

    task automatic test_rounding();
        int y0, y1, l0, l1, exp_y4;
        logic d0, d1;
`ifdef FIR_INTERP2_ROUND_EN
        exp_y4 = 2;
`else
        exp_y4 = 1;
`endif
        do_reset();
        model_push(3); push(3, 0, y0, y1, l0, l1, d0, d1);
        model_push(0); push(0, 0, y0, y1, l0, l1, d0, d1);
        model_push(0); push(0, 0, y0, y1, l0, l1, d0, d1);
        checks++;
        if (y0 !== exp_y4 || y0 !== model_y(0)) begin
            failures++;
            $display("FAIL round_y4: got %0d expected %0d", y0, exp_y4);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        test_reset();
        test_impulse("impulse", 1'b1);
        test_dc();
        test_backpressure();
        test_busy();
        test_random();
        test_reset_mid();
        test_rounding();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
